// File: rtl/crd_drop_unit.sv
// Coordinate dropper: forwards an outer coordinate only when its inner fiber
// holds at least one data token; the inner stream passes through unchanged.

module crd_drop_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= bump(wr_ptr);
        if (pop)  rd_ptr <= bump(rd_ptr);
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && !flush && push) mem[wr_ptr] <= din;
  end
endmodule

module crd_drop_unit #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        flush,
  input  logic        tile_en,
  input  logic [16:0] outer_crd_in,
  input  logic        outer_crd_in_valid,
  output logic        outer_crd_in_ready,
  input  logic [16:0] inner_crd_in,
  input  logic        inner_crd_in_valid,
  output logic        inner_crd_in_ready,
  output logic [16:0] outer_crd_out,
  output logic        outer_crd_out_valid,
  input  logic        outer_crd_out_ready,
  output logic [16:0] inner_crd_out,
  output logic        inner_crd_out_valid,
  input  logic        inner_crd_out_ready,
  output logic        protocol_error
);
  localparam logic [16:0] DONE_TOK = 17'h10100;

  typedef enum logic [1:0] {IDLE, FIBER, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [16:0] held_crd, held_nxt;
  logic        nonempty, nonempty_nxt;
  logic        err_set;

  logic        en;
  logic        push_o, push_i, pop_o, pop_i;
  logic        o_empty, o_full, i_empty, i_full;
  logic        o_space, i_space;
  logic [16:0] din_o;

  logic o_is_data, o_is_done, o_is_stop;
  logic i_is_data, i_is_done, i_is_stop;

  // Flush and a frozen clock both block every handshake at the ports.
  assign en = clk_en & tile_en & ~flush;

  assign o_is_data = ~outer_crd_in[16];
  assign o_is_done = (outer_crd_in == DONE_TOK);
  assign o_is_stop = outer_crd_in[16] & ~o_is_done;
  assign i_is_data = ~inner_crd_in[16];
  assign i_is_done = (inner_crd_in == DONE_TOK);
  assign i_is_stop = inner_crd_in[16] & ~i_is_done;

  assign outer_crd_out_valid = en & ~o_empty;
  assign inner_crd_out_valid = en & ~i_empty;
  assign pop_o = outer_crd_out_valid & outer_crd_out_ready;
  assign pop_i = inner_crd_out_valid & inner_crd_out_ready;

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign o_space = ~o_full | pop_o;
  assign i_space = ~i_full | pop_i;

  always_comb begin
    state_nxt          = state;
    held_nxt           = held_crd;
    nonempty_nxt       = nonempty;
    err_set            = 1'b0;
    push_o             = 1'b0;
    push_i             = 1'b0;
    din_o              = held_crd;
    outer_crd_in_ready = 1'b0;
    inner_crd_in_ready = 1'b0;
    case (state)
      IDLE: begin
        outer_crd_in_ready = en & (~o_is_stop | o_space);
        if (outer_crd_in_valid && outer_crd_in_ready) begin
          if (o_is_data) begin
            held_nxt     = outer_crd_in;
            nonempty_nxt = 1'b0;
            state_nxt    = FIBER;
          end else if (o_is_done) begin
            state_nxt = DRAIN;
          end else begin
            push_o = 1'b1;
            din_o  = outer_crd_in;
          end
        end
      end
      FIBER: begin
        inner_crd_in_ready = en & i_space & (~(i_is_stop & nonempty) | o_space);
        if (inner_crd_in_valid && inner_crd_in_ready) begin
          push_i = 1'b1;
          if (i_is_data) begin
            nonempty_nxt = 1'b1;
          end else if (i_is_done) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end else begin
            push_o    = nonempty;
            state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        inner_crd_in_ready = en & i_space & (~i_is_done | o_space);
        if (inner_crd_in_valid && inner_crd_in_ready) begin
          push_i = 1'b1;
          if (i_is_done) begin
            push_o    = 1'b1;
            din_o     = DONE_TOK;
            state_nxt = IDLE;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      held_crd       <= '0;
      nonempty       <= 1'b0;
      protocol_error <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        state          <= IDLE;
        held_crd       <= '0;
        nonempty       <= 1'b0;
        protocol_error <= 1'b0;
      end else begin
        state    <= state_nxt;
        held_crd <= held_nxt;
        nonempty <= nonempty_nxt;
        if (err_set) protocol_error <= 1'b1;
      end
    end
  end

  crd_drop_fifo #(.DEPTH(FIFO_DEPTH), .W(17)) u_outer_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_en(clk_en),
    .flush (flush),
    .push  (push_o),
    .pop   (pop_o),
    .din   (din_o),
    .dout  (outer_crd_out),
    .empty (o_empty),
    .full  (o_full)
  );

  crd_drop_fifo #(.DEPTH(FIFO_DEPTH), .W(17)) u_inner_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_en(clk_en),
    .flush (flush),
    .push  (push_i),
    .pop   (pop_i),
    .din   (inner_crd_in),
    .dout  (inner_crd_out),
    .empty (i_empty),
    .full  (i_full)
  );
endmodule

// File: tb/tb_crd_drop_unit.sv
// Directed bench for crd_drop_unit: stream tables with hand-derived outputs.

module tb_crd_drop_unit;
  localparam logic [16:0] S0 = 17'h10000;
  localparam logic [16:0] S1 = 17'h10001;
  localparam logic [16:0] DN = 17'h10100;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush, tile_en;
  logic [16:0] outer_crd_in, inner_crd_in, outer_crd_out, inner_crd_out;
  logic        outer_crd_in_valid, outer_crd_in_ready;
  logic        inner_crd_in_valid, inner_crd_in_ready;
  logic        outer_crd_out_valid, outer_crd_out_ready;
  logic        inner_crd_out_valid, inner_crd_out_ready;
  logic        protocol_error;

  logic [16:0] src_o[$], src_i[$], exp_o[$], exp_i[$], got_o[$], got_i[$];
  int n_cmp = 0;
  int n_err = 0;
  bit stall_seen;

  always #5 clk = ~clk;

  crd_drop_unit #(.FIFO_DEPTH(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .clk_en             (clk_en),
    .flush              (flush),
    .tile_en            (tile_en),
    .outer_crd_in       (outer_crd_in),
    .outer_crd_in_valid (outer_crd_in_valid),
    .outer_crd_in_ready (outer_crd_in_ready),
    .inner_crd_in       (inner_crd_in),
    .inner_crd_in_valid (inner_crd_in_valid),
    .inner_crd_in_ready (inner_crd_in_ready),
    .outer_crd_out      (outer_crd_out),
    .outer_crd_out_valid(outer_crd_out_valid),
    .outer_crd_out_ready(outer_crd_out_ready),
    .inner_crd_out      (inner_crd_out),
    .inner_crd_out_valid(inner_crd_out_valid),
    .inner_crd_out_ready(inner_crd_out_ready),
    .protocol_error     (protocol_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_basic();
    src_o = '{17'd3, 17'd7, 17'd9, S0, DN};
    src_i = '{17'd4, 17'd5, S0, S0, 17'd8, S1, DN};
    exp_o = '{17'd3, 17'd9, S0, DN};
    exp_i = src_i;
  endtask

  // Drives both sources from their queues and collects both outputs.
  task automatic run_stream(input string tag, input int budget, input bit rnd,
                            input int bp_len, input int stop_after, input bit chk_err);
    int cyc = 0;
    int bp = 0;
    int ifires = 0;
    int err_at = -1;
    bit bp_started = 1'b0;
    bit timed_out = 1'b0;
    stall_seen = 1'b0;
    got_o.delete();
    got_i.delete();
    forever begin
      outer_crd_in_valid  = (src_o.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      outer_crd_in        = (src_o.size() != 0) ? src_o[0] : '0;
      inner_crd_in_valid  = (src_i.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      inner_crd_in        = (src_i.size() != 0) ? src_i[0] : '0;
      outer_crd_out_ready = (bp == 0) && (!rnd || $urandom_range(0, 3) != 0);
      inner_crd_out_ready = !rnd || $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (bp > 0 && inner_crd_in_valid && !inner_crd_in_ready && inner_crd_in[16])
        stall_seen = 1'b1;
      if (bp > 0) bp--;
      if (err_at == cyc) chk({tag, "_err_rise"}, 32'(protocol_error), 1);
      if (outer_crd_in_valid && outer_crd_in_ready) void'(src_o.pop_front());
      if (inner_crd_in_valid && inner_crd_in_ready) begin
        if (bp_len > 0 && !bp_started && inner_crd_in == S0) begin
          bp_started = 1'b1;
          bp = bp_len;
        end
        if (chk_err && inner_crd_in == DN) begin
          chk({tag, "_err_pre"}, 32'(protocol_error), 0);
          err_at = cyc + 1;
        end
        void'(src_i.pop_front());
        ifires++;
      end
      if (outer_crd_out_valid && outer_crd_out_ready) got_o.push_back(outer_crd_out);
      if (inner_crd_out_valid && inner_crd_out_ready) got_i.push_back(inner_crd_out);
      @(posedge clk);
      #1;
      cyc++;
      if (stop_after != 0 && ifires == stop_after) break;
      if (src_o.size() == 0 && src_i.size() == 0 &&
          got_o.size() == exp_o.size() && got_i.size() == exp_i.size() && err_at < cyc) break;
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
    end
    chk({tag, "_in_budget"}, 32'(timed_out), 0);
    outer_crd_in_valid = 1'b0;
    inner_crd_in_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input bit perr);
    int extra = 0;
    chk({tag, "_osize"}, got_o.size(), exp_o.size());
    chk({tag, "_isize"}, got_i.size(), exp_i.size());
    for (int k = 0; k < got_o.size() && k < exp_o.size(); k++)
      chk({tag, "_otok"}, 32'(got_o[k]), 32'(exp_o[k]));
    for (int k = 0; k < got_i.size() && k < exp_i.size(); k++)
      chk({tag, "_itok"}, 32'(got_i[k]), 32'(exp_i[k]));
    outer_crd_out_ready = 1'b1;
    inner_crd_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (outer_crd_out_valid || inner_crd_out_valid) extra++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_extra"}, extra, 0);
    chk({tag, "_perr"}, 32'(protocol_error), 32'(perr));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
    outer_crd_in = '0; inner_crd_in = '0;
    outer_crd_in_valid = 1'b0; inner_crd_in_valid = 1'b0;
    outer_crd_out_ready = 1'b1; inner_crd_out_ready = 1'b1;

    @(negedge clk);
    chk("rst_oval", 32'(outer_crd_out_valid), 0);
    chk("rst_ival", 32'(inner_crd_out_valid), 0);
    chk("rst_ordy", 32'(outer_crd_in_ready), 1);
    chk("rst_irdy", 32'(inner_crd_in_ready), 0);
    chk("rst_perr", 32'(protocol_error), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    tile_en = 1'b0;
    outer_crd_in = S0; outer_crd_in_valid = 1'b1;
    @(negedge clk);
    chk("tile_ordy", 32'(outer_crd_in_ready), 0);
    @(posedge clk);
    #1;
    tile_en = 1'b1;
    clk_en = 1'b0;
    outer_crd_out_ready = 1'b0;
    @(negedge clk);
    chk("ce_ordy", 32'(outer_crd_in_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ce_oval", 32'(outer_crd_out_valid), 0);
    @(posedge clk);
    #1;
    clk_en = 1'b1;
    @(negedge clk);
    chk("stop_ordy", 32'(outer_crd_in_ready), 1);
    chk("stop_pre_oval", 32'(outer_crd_out_valid), 0);
    @(posedge clk);
    #1;
    outer_crd_in_valid = 1'b0;
    @(negedge clk);
    chk("stop_lat_oval", 32'(outer_crd_out_valid), 1);
    chk("stop_lat_data", 32'(outer_crd_out), 32'(S0));
    @(posedge clk);
    #1;
    outer_crd_out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stop_popped", 32'(outer_crd_out_valid), 0);
    @(posedge clk);
    #1;

    load_basic();
    run_stream("basic", 200, 1'b0, 0, 0, 1'b0);
    check_outputs("basic", 1'b0);

    src_o = '{17'd1, 17'd2, S0, DN};
    src_i = '{S0, S1, DN};
    exp_o = '{S0, DN};
    exp_i = src_i;
    run_stream("empty", 200, 1'b0, 0, 0, 1'b0);
    check_outputs("empty", 1'b0);

    load_basic();
    run_stream("bp", 300, 1'b0, 10, 0, 1'b0);
    check_outputs("bp", 1'b0);

    src_o = '{17'd1, 17'd2, 17'd3, DN};
    src_i = '{17'd7, S0, 17'd8, S0, 17'd9, S0, DN};
    exp_o = '{17'd1, 17'd2, 17'd3, DN};
    exp_i = src_i;
    run_stream("joint", 300, 1'b0, 10, 0, 1'b0);
    chk("joint_inner_stall", 32'(stall_seen), 1);
    check_outputs("joint", 1'b0);

    load_basic();
    run_stream("rand", 1000, 1'b1, 0, 0, 1'b0);
    check_outputs("rand", 1'b0);

    src_o = '{17'd5, DN};
    src_i = '{17'd6, DN};
    exp_o.delete();
    exp_i = src_i;
    run_stream("err", 200, 1'b0, 0, 0, 1'b1);
    check_outputs("err", 1'b1);
    @(negedge clk);
    chk("err_sticky", 32'(protocol_error), 1);
    @(posedge clk);
    #1;
    pulse_flush();
    @(negedge clk);
    chk("err_flush_perr", 32'(protocol_error), 0);
    chk("err_flush_ordy", 32'(outer_crd_in_ready), 1);
    @(posedge clk);
    #1;

    load_basic();
    run_stream("mid", 200, 1'b0, 0, 4, 1'b0);
    pulse_flush();
    @(negedge clk);
    chk("flush_oval", 32'(outer_crd_out_valid), 0);
    chk("flush_ival", 32'(inner_crd_out_valid), 0);
    chk("flush_ordy", 32'(outer_crd_in_ready), 1);
    chk("flush_irdy", 32'(inner_crd_in_ready), 0);
    @(posedge clk);
    #1;
    load_basic();
    run_stream("replay", 200, 1'b0, 0, 0, 1'b0);
    check_outputs("replay", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
